// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches (one outstanding at a
// time) and buffers returned instructions with their PCs in a small FIFO for decode.
// A redirect flushes the FIFO, withdraws any unaccepted request and discards the
// response of a fetch that is still in flight.
module inst_prefetch_queue #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       redirect,
   input  logic [XLEN-1:0]            redirect_pc,
   output logic                       mem_req_valid,
   output logic [XLEN-1:0]            mem_req_addr,
   input  logic                       mem_req_ready,
   input  logic                       mem_rsp_valid,
   input  logic [31:0]                mem_rsp_data,
   output logic                       out_valid,
   output logic [31:0]                out_inst,
   output logic [XLEN-1:0]            out_pc,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   // IDLE: may request; WAIT: fetch outstanding; DRAIN: outstanding fetch is stale
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]      r_state;
   logic [1:0]      w_state_nxt;
   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_req_pc;

   logic [31:0]     r_mem_inst [DEPTH];
   logic [XLEN-1:0] r_mem_pc   [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_count_nxt;
   logic            r_out_valid;

   logic            w_req_valid;
   logic            w_req_fire;
   logic            w_push;
   logic            w_pop;
   logic [XLEN-1:0] w_redirect_pc;
   logic            w_unused;

   // Credit check: only request while a slot is guaranteed free for the response.
   assign w_req_valid   = (r_state == S_IDLE) && (r_count < CW'(DEPTH)) && !redirect && !rst;
   assign w_req_fire    = w_req_valid && mem_req_ready;
   // Only a response to a live fetch is queued; a redirect in the same cycle kills it.
   assign w_push        = (r_state == S_WAIT) && mem_rsp_valid && !redirect;
   assign w_pop         = r_out_valid && out_ready && !redirect;
   assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};
   assign w_unused      = &{1'b0, redirect_pc[1:0]};

   assign mem_req_valid = w_req_valid;
   assign mem_req_addr  = r_fetch_pc;
   assign out_valid     = r_out_valid;
   assign out_inst      = r_mem_inst[r_rd_ptr];
   assign out_pc        = r_mem_pc[r_rd_ptr];
   assign count         = r_count;

   // Fetch FSM next-state: a response always closes the outstanding fetch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_req_fire) begin
               w_state_nxt = S_WAIT;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            if (mem_rsp_valid) begin
               w_state_nxt = S_IDLE;
            end else if (redirect) begin
               w_state_nxt = S_DRAIN;
            end else begin
               w_state_nxt = S_WAIT;
            end
         end
         S_DRAIN: begin
            if (mem_rsp_valid) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_DRAIN;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Occupancy update: push and pop together leave the count unchanged.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // FSM state and fetch/request PC registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (redirect) begin
            r_fetch_pc <= w_redirect_pc;
         end else if (w_req_fire) begin
            r_fetch_pc <= r_fetch_pc + XLEN'(4);
         end
         if (w_req_fire) begin
            r_req_pc <= r_fetch_pc;
         end
      end
   end

   // FIFO control: pointers, count and registered head-valid; redirect flushes.
   always_ff @(posedge clk) begin
      if (rst || redirect) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_count     <= w_count_nxt;
         r_out_valid <= (w_count_nxt != '0);
      end
   end

   // FIFO storage: instruction word with the PC it was fetched from.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_inst[r_wr_ptr] <= mem_rsp_data;
         r_mem_pc[r_wr_ptr]   <= r_req_pc;
      end
   end

endmodule
